keypad_scan_ctrl: RTL and testbench

- Scan sequencer for the 4x4 matrix keypad. Drives one column at a time, samples the rows, debounces a press and encodes it to a 4-bit key code.
- Delivers each key press to downstream logic (seven-segment display driver, etc.) through a valid/ack handshake.
- Sits between the keypad pins and the top level. Replaces free-running slow-clock scanning with a single-clock, tick-enabled FSM.

---
 rtl/keypad_pkg.sv | 32 +++
 rtl/keypad_scan_ctrl_tick_gen.sv | 39 +++
 rtl/keypad_scan_ctrl.sv | 155 +++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HOLD     = 2'd2
    } state_e;

    // Indexed [row][col]; row 3 carries the '*'(E) and '#'(F) keys.
    localparam logic [3:0] KEYMAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    function automatic logic [1:0] lowest_row(input logic [3:0] rows);
        logic [1:0] idx;
        if (rows[0]) begin
            idx = 2'd0;
        end else if (rows[1]) begin
            idx = 2'd1;
        end else if (rows[2]) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scan_ctrl_tick_gen.sv
// Free-running divider producing a one-cycle scan tick every TICK_DIV clocks.
module scan_tick_gen #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    // Next count and look-ahead tick so the pulse comes from a register.
    always_comb begin
        if (cnt_q == LAST) begin
            cnt_d = {CW{1'b0}};
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        tick_d = (cnt_d == LAST);
    end

    // Divider state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q  <= {CW{1'b0}};
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Column scanner, press/release debouncer and valid/ack key delivery.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int CLK_HZ     = 27000000,
    parameter int SCAN_HZ    = 1000,
    parameter int DEBOUNCE_N = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_out,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       key_pressed,
    output logic       overrun
);

    localparam int TICK_DIV = CLK_HZ / SCAN_HZ;
    localparam int CNT_W    = $clog2(DEBOUNCE_N + 1);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_N);

    state_e           state_q, state_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [1:0]       row_q, row_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       col_out_q, col_out_d;
    logic [3:0]       key_q, key_d;
    logic             valid_q, valid_d;
    logic             pressed_q, pressed_d;
    logic             overrun_q, overrun_d;
    logic             tick_s, accept_s, ack_s;
    logic [CNT_W-1:0] cnt_inc_s;

    scan_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick_s)
    );

    assign cnt_inc_s = cnt_q + CNT_W'(1);

    // Scan/debounce/hold sequencing; one counter serves press and release.
    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        row_d     = row_q;
        cnt_d     = cnt_q;
        pressed_d = pressed_q;
        accept_s  = 1'b0;
        case (state_q)
            SCAN: begin
                if (tick_s && (row_in == 4'b0000)) begin
                    col_idx_d = col_idx_q + 2'd1;
                end else if (tick_s) begin
                    row_d   = lowest_row(row_in);
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = DEBOUNCE;
                end else begin
                    state_d = SCAN;
                end
            end
            DEBOUNCE: begin
                if (tick_s && row_in[row_q] && (cnt_inc_s == DB_LAST)) begin
                    accept_s  = 1'b1;
                    pressed_d = 1'b1;
                    cnt_d     = {CNT_W{1'b0}};
                    state_d   = HOLD;
                end else if (tick_s && row_in[row_q]) begin
                    cnt_d = cnt_inc_s;
                end else if (tick_s) begin
                    cnt_d     = {CNT_W{1'b0}};
                    col_idx_d = col_idx_q + 2'd1;
                    state_d   = SCAN;
                end else begin
                    state_d = DEBOUNCE;
                end
            end
            HOLD: begin
                if (tick_s && !row_in[row_q] && (cnt_inc_s == DB_LAST)) begin
                    pressed_d = 1'b0;
                    cnt_d     = {CNT_W{1'b0}};
                    col_idx_d = col_idx_q + 2'd1;
                    state_d   = SCAN;
                end else if (tick_s && !row_in[row_q]) begin
                    cnt_d = cnt_inc_s;
                end else if (tick_s) begin
                    cnt_d = {CNT_W{1'b0}};
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = SCAN;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Handshake: an ack coinciding with an accept retires the old key silently.
    always_comb begin
        ack_s     = key_ack & valid_q;
        col_out_d = 4'b0001 << col_idx_d;
        if (accept_s) begin
            key_d   = KEYMAP[row_q][col_idx_q];
            valid_d = 1'b1;
        end else if (ack_s) begin
            key_d   = key_q;
            valid_d = 1'b0;
        end else begin
            key_d   = key_q;
            valid_d = valid_q;
        end
        if (accept_s && valid_q && !key_ack) begin
            overrun_d = 1'b1;
        end else if (ack_s && !accept_s) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= SCAN;
            col_idx_q <= 2'd0;
            row_q     <= 2'd0;
            cnt_q     <= {CNT_W{1'b0}};
            col_out_q <= 4'b0001;
            key_q     <= 4'h0;
            valid_q   <= 1'b0;
            pressed_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_idx_q <= col_idx_d;
            row_q     <= row_d;
            cnt_q     <= cnt_d;
            col_out_q <= col_out_d;
            key_q     <= key_d;
            valid_q   <= valid_d;
            pressed_q <= pressed_d;
            overrun_q <= overrun_d;
        end
    end

    assign col_out     = col_out_q;
    assign key_out     = key_q;
    assign key_valid   = valid_q;
    assign key_pressed = pressed_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Scoreboard bench for keypad_scan_ctrl with TICK_DIV=4, DEBOUNCE_N=2.
module tb_keypad_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_out;
    logic       key_valid;
    logic       key_ack;
    logic       key_pressed;
    logic       overrun;

    int         n_total = 0;
    int         n_bad   = 0;
    logic [3:0] exp_q[$];
    logic       pressed_prev = 1'b0;

    always #5 clk = ~clk;

    keypad_scan_ctrl #(
        .CLK_HZ     (16),
        .SCAN_HZ    (4),
        .DEBOUNCE_N (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .row_in      (row_in),
        .col_out     (col_out),
        .key_out     (key_out),
        .key_valid   (key_valid),
        .key_ack     (key_ack),
        .key_pressed (key_pressed),
        .overrun     (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Each accept raises key_pressed; compare the delivered code to the scoreboard.
    always @(negedge clk) begin
        if (rst && key_pressed && !pressed_prev) begin
            chk("sb_pending", exp_q.size(), 1);
            if (exp_q.size() > 0) chk("key_code", key_out, exp_q.pop_front());
            chk("valid_on_accept", key_valid, 1);
        end
        pressed_prev = key_pressed;
    end

    task automatic wait_col(input int c);
        logic [3:0] tgt;
        logic [3:0] prev;
        logic       found;
        tgt   = 4'b0001 << c;
        prev  = col_out;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (col_out == tgt && prev != tgt) begin
                found = 1'b1;
                break;
            end
            prev = col_out;
        end
        chk("col_wait", found, 1);
    endtask

    task automatic press_key(input int c, input logic [3:0] rows, input logic [3:0] code,
                             input logic ack_acc, input logic exp_ovr);
        int n;
        wait_col(c);
        row_in = rows;
        exp_q.push_back(code);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n++;
            if (n == 11 && ack_acc) key_ack = 1'b1;
            if (key_pressed) break;
        end
        key_ack = 1'b0;
        chk("accept_latency", n, 12);
        chk("overrun_after_accept", overrun, exp_ovr);
    endtask

    task automatic release_key(input logic rebounce, input logic do_ack, input int next_c,
                               input int exp_n);
        logic [3:0] row_sv;
        int         n;
        row_sv = row_in;
        row_in = 4'b0000;
        if (do_ack) key_ack = 1'b1;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                key_ack = 1'b0;
                if (do_ack) begin
                    chk("ack_clears_valid", key_valid, 0);
                    chk("ack_clears_overrun", overrun, 0);
                end
            end
            if (rebounce && n == 4) row_in = row_sv;
            if (rebounce && n == 8) row_in = 4'b0000;
            if (!key_pressed) break;
        end
        chk("release_latency", n, exp_n);
        chk("col_after_release", col_out, 4'b0001 << next_c);
    endtask

    initial begin
        rst     = 1'b0;
        row_in  = 4'b0000;
        key_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_col", col_out, 4'b0001);
        chk("rst_key", key_out, 4'h0);
        chk("rst_valid", key_valid, 0);
        chk("rst_pressed", key_pressed, 0);
        chk("rst_overrun", overrun, 0);
        rst = 1'b1;
        for (int k = 1; k < 20; k++) begin
            @(negedge clk);
            chk("idle_col", col_out, 4'b0001 << ((k / 4) % 4));
        end

        // Clean press on row 1 / col 3, acked at the start of release.
        press_key(3, 4'b0010, 4'hB, 1'b0, 1'b0);
        release_key(1'b0, 1'b1, 0, 8);

        // One-tick bounce on column 0: scan must resume at column 1.
        wait_col(0);
        row_in = 4'b0001;
        repeat (4) @(negedge clk);
        row_in = 4'b0000;
        repeat (3) @(negedge clk);
        chk("bounce_frozen", col_out, 4'b0001);
        @(negedge clk);
        chk("bounce_resume", col_out, 4'b0010);
        chk("bounce_no_press", key_pressed, 0);

        // '5' left pending with a re-bounce on release, then '0' overruns it.
        press_key(1, 4'b0010, 4'h5, 1'b0, 1'b0);
        release_key(1'b1, 1'b0, 2, 16);
        press_key(1, 4'b1000, 4'h0, 1'b0, 1'b1);
        release_key(1'b0, 1'b1, 2, 8);

        // Reset during DEBOUNCE discards the pending press.
        wait_col(2);
        row_in = 4'b0010;
        repeat (6) @(negedge clk);
        rst    = 1'b0;
        row_in = 4'b0000;
        repeat (2) @(negedge clk);
        chk("midrst_col", col_out, 4'b0001);
        chk("midrst_valid", key_valid, 0);
        chk("midrst_pressed", key_pressed, 0);
        rst = 1'b1;

        // Ack landing on the same edge as a new accept.
        press_key(0, 4'b0001, 4'h1, 1'b0, 1'b0);
        release_key(1'b0, 1'b0, 1, 8);
        press_key(2, 4'b0100, 4'h9, 1'b1, 1'b0);
        chk("collide_valid", key_valid, 1);
        release_key(1'b0, 1'b1, 3, 8);

        repeat (20) @(negedge clk);
        chk("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
